seq_mult_param: RTL
===================

Name: seq_mult_param

Overview:
Parametrised sequential add-shift multiplier. It is the WIDTH-generic successor of the 8-bit lab multiplier datapath and controller, with a selectable signed or unsigned mode and an explicit Busy/Done handshake. The multiplicand is captured internally at start, so changes on Din during a run do not affect the result. It sits between the debounced switch/button synchronisers and the hex display, exposing X, A and B plus the full product.

Parameters:
WIDTH, 8, operand width in bits; legal range 2 to 32.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Load_B  input  1  synchronised level; in IDLE, loads B from Din and clears X and A.
Start  input  1  synchronised level; in IDLE, begins a multiply.
Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at start.
Din  input  WIDTH  switch value; multiplier on Load_B, multiplicand on Start.
Xval  output  1  X (sign/carry) register.
Aval  output  WIDTH  A register (product high half).
Bval  output  WIDTH  B register (product low half).
Product  output  2*WIDTH  {Aval, Bval}.
Busy  output  1  high while in CALC.
Done  output  1  high while in DONE.

Behaviour:
- Reset, asynchronous and at any time including mid-run:
  - X, A, B, S (internal multiplicand), mode register and counter all go to 0.
  - State goes to IDLE; Busy = 0, Done = 0.
- States: IDLE, CALC, DONE. Busy and Done are Moore outputs of the state.
- IDLE:
  - Load_B = 1: B <= Din, A <= 0, X <= 0; stay in IDLE.
  - Load_B has priority: if Load_B and Start are both 1, only the load happens.
  - Start = 1 and Load_B = 0:
    - S <= Din, mode <= Signed_Mode.
    - A <= 0, X <= 0 (consecutive-run clear); B is kept.
    - cnt <= 0; go to CALC.
- CALC, one iteration per cycle, WIDTH cycles total:
  - ext() is a (WIDTH+1)-bit sign extension in signed mode and zero extension in unsigned mode.
  - T = ext(A) + ext(S) if B[0] = 1, otherwise T = ext(A).
  - Exception: in signed mode on the last iteration (cnt = WIDTH-1) with B[0] = 1, T = ext(A) - ext(S).
  - Register updates, all in the same cycle:
    - A <= T[WIDTH:1].
    - B <= {T[0], B[WIDTH-1:1]}.
    - X <= T[WIDTH] in signed mode, 0 in unsigned mode.
    - cnt <= cnt + 1.
  - When cnt = WIDTH-1, go to DONE.
  - Start, Load_B, Din and Signed_Mode are ignored in CALC.
- DONE:
  - Registers hold.
  - Stay in DONE while Start = 1; one press gives exactly one multiply.
  - Go to IDLE when Start = 0.
  - Load_B is ignored until the block is back in IDLE.
- Latency: Done first reads high after WIDTH+1 rising edges, counting the edge that sampled Start.
- Result: Product equals the exact 2*WIDTH-bit product of B (at start) and S, signed or unsigned per mode.
  - Signed corner case: -2^(W-1) * -2^(W-1) gives +2^(2W-2) without overflow.
- The counter uses $clog2(WIDTH) bits; no wrap-around occurs within a run.

Test Plan:
- WIDTH=8, signed: Load_B with Din=0xFF, then Start with Din=0xFF. Expect Product=0x0001, X=0. Done rises exactly 9 edges after the Start edge; Busy is high for 8 cycles.
- WIDTH=8, signed: B=0x80, S=0x80 -> Product=0x4000. With B=0x07, S=0xC5 (7 * -59) -> Product=0xFE63, X=1.
- WIDTH=8, unsigned: B=0xFF, S=0xFF -> Product=0xFE01, X=0. WIDTH=16, unsigned: 0xFFFF*0xFFFF -> 0xFFFE0001 after 17 edges.
- Handshake:
  - Hold Start high past Done -> block stays in DONE and no second run starts.
  - Release Start, press again without Load_B, S=0x02 -> A/X are cleared and the new result equals old B * 2.
  - Toggling Din during CALC does not change the result.
- Priority and ignore rules:
  - Load_B and Start asserted in the same IDLE cycle -> B loaded, Busy stays 0.
  - Load_B pulsed during CALC -> ignored; the result is unchanged.
- Reset asserted on the 4th CALC cycle, between clock edges -> Aval, Bval and Xval are 0 immediately, asynchronously. Busy and Done are 0, and the block is in IDLE.

Source files
------------

// File: rtl/seq_mult_param.sv
// Parametrised sequential add-shift multiplier with signed/unsigned mode.
// One partial-product iteration per clock; WIDTH iterations per multiply.
// The result accumulates in {A, B}; X carries the sign/carry bit of the last sum.
// The multiplicand S is captured at start, so Din may change freely during a run.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load_B,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Din,
  output logic                 Xval,
  output logic [WIDTH-1:0]     Aval,
  output logic [WIDTH-1:0]     Bval,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             x_reg, x_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             mode_reg, mode_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_s;
  logic [WIDTH:0]   sum_t;
  logic             last_iter;

  // Partial-product arithmetic: extend A and S by one bit, then add, subtract or pass A.
  // The final signed iteration subtracts because the multiplier's MSB carries negative weight.
  always_comb begin
    ext_a     = mode_reg ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    ext_s     = mode_reg ? {s_reg[WIDTH-1], s_reg} : {1'b0, s_reg};
    last_iter = (cnt_reg == LAST);
    sum_t     = ext_a;
    if (b_reg[0]) begin
      if (mode_reg && last_iter) begin
        sum_t = ext_a - ext_s;
      end else begin
        sum_t = ext_a + ext_s;
      end
    end
  end

  // Next-state and datapath-update logic; everything holds unless the state says otherwise.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (Load_B) begin
          // Load wins over Start when both are pressed together.
          b_next = Din;
          a_next = '0;
          x_next = 1'b0;
        end else if (Start) begin
          // B is kept so a second press can reuse the previous low half.
          s_next     = Din;
          mode_next  = Signed_Mode;
          a_next     = '0;
          x_next     = 1'b0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        a_next   = sum_t[WIDTH:1];
        b_next   = {sum_t[0], b_reg[WIDTH-1:1]};
        x_next   = mode_reg & sum_t[WIDTH];
        cnt_next = cnt_reg + CW'(1);
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Waiting for Start release guarantees one multiply per press.
        if (!Start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; reset clears everything, including mid-run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_reg    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      mode_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      x_reg    <= x_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      s_reg    <= s_next;
      mode_reg <= mode_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign Xval    = x_reg;
  assign Aval    = a_reg;
  assign Bval    = b_reg;
  assign Product = {a_reg, b_reg};
  assign Busy    = (state_reg == CALC);
  assign Done    = (state_reg == DONE);

endmodule
